// File: rtl/uart_tx_scheduler.sv
// Two-requester UART transmitter: round-robin byte arbitration, 8N/8E/8O framing with 1 or 2 stops.
// Optional line-break generator is compiled in with UART_TX_SCHED_BREAK_EN.
module uart_tx_scheduler #(
  parameter int CLKS_PER_BIT = 16
`ifdef UART_TX_SCHED_BREAK_EN
  , parameter int BREAK_BITS = 12
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  input  logic [1:0] parity_type,
  input  logic       stop_bits,
`ifdef UART_TX_SCHED_BREAK_EN
  input  logic       break_req,
`endif
  output logic       tx_line,
  output logic       tx_active,
  output logic       tx_done,
  output logic       grant_id
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  // Last stop bit ends one cycle early: the IDLE cycle that follows is its final high cycle.
  localparam logic [CW-1:0] STOP_LAST = CW'(CLKS_PER_BIT - 2);
`ifdef UART_TX_SCHED_BREAK_EN
  localparam int BW = (BREAK_BITS > 1) ? $clog2(BREAK_BITS + 1) : 1;
  localparam logic [BW-1:0] BRK_LAST = BW'(BREAK_BITS - 1);
`endif

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
`ifdef UART_TX_SCHED_BREAK_EN
    , ST_BREAK = 3'd5
`endif
  } state_t;

  function automatic logic parity_bit(input logic [7:0] d, input logic [1:0] t);
    case (t)
      2'b01:   parity_bit = ~^d;
      2'b10:   parity_bit = ^d;
      default: parity_bit = 1'b0;
    endcase
  endfunction

  function automatic logic parity_on(input logic [1:0] t);
    parity_on = (t == 2'b01) || (t == 2'b10);
  endfunction

  state_t         state_r, state_n;
  logic [CW-1:0]  cnt_r, cnt_n;
  logic [2:0]     bit_r, bit_n;
  logic [7:0]     data_r, data_n;
  logic [1:0]     par_r, par_n;
  logic           stop2_r, stop2_n;
  logic           grant_r, grant_n;
  logic           ptr_r, ptr_n;
  logic           line_r, line_n;
  logic           active_r, active_n;
  logic           done_r, done_n;
`ifdef UART_TX_SCHED_BREAK_EN
  logic [BW-1:0]  brk_cnt_r, brk_cnt_n;
`endif

  logic brk_s;
  logic any_valid_s;
  logic win1_s;
  logic accept_s;
  logic baud_end_s;
  logic last_stop_s;
  logic [2:0] bit_inc_s;

`ifdef UART_TX_SCHED_BREAK_EN
  assign brk_s = break_req;
`else
  assign brk_s = 1'b0;
`endif

  assign any_valid_s = req0_valid | req1_valid;
  // Under contention the requester that did not own the previous frame wins.
  assign win1_s      = req1_valid & (~req0_valid | ~ptr_r);
  assign accept_s    = (state_r == ST_IDLE) & any_valid_s & ~brk_s;
  assign req0_ready  = rst & accept_s & ~win1_s;
  assign req1_ready  = rst & accept_s & win1_s;
  assign baud_end_s  = (cnt_r == BAUD_LAST);
  assign last_stop_s = (bit_r[0] == stop2_r);
  assign bit_inc_s   = bit_r + 3'd1;

  assign tx_line   = line_r;
  assign tx_active = active_r;
  assign tx_done   = done_r;
  assign grant_id  = grant_r;

  // Next-state, counters and next line level
  always_comb begin
    state_n  = state_r;
    cnt_n    = cnt_r;
    bit_n    = bit_r;
    data_n   = data_r;
    par_n    = par_r;
    stop2_n  = stop2_r;
    grant_n  = grant_r;
    ptr_n    = ptr_r;
    line_n   = line_r;
    active_n = active_r;
    done_n   = 1'b0;
`ifdef UART_TX_SCHED_BREAK_EN
    brk_cnt_n = brk_cnt_r;
`endif
    if (state_r != ST_IDLE) begin
      cnt_n = baud_end_s ? '0 : cnt_r + CW'(1);
    end else begin
      cnt_n = '0;
    end
    case (state_r)
      ST_IDLE: begin
        bit_n    = 3'd0;
        line_n   = 1'b1;
        active_n = 1'b0;
`ifdef UART_TX_SCHED_BREAK_EN
        if (brk_s) begin
          state_n   = ST_BREAK;
          line_n    = 1'b0;
          active_n  = 1'b1;
          brk_cnt_n = '0;
        end else
`endif
        if (any_valid_s) begin
          state_n  = ST_START;
          line_n   = 1'b0;
          active_n = 1'b1;
          data_n   = win1_s ? req1_data : req0_data;
          par_n    = parity_type;
          stop2_n  = stop_bits;
          grant_n  = win1_s;
          ptr_n    = win1_s;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_START: begin
        if (baud_end_s) begin
          state_n = ST_DATA;
          line_n  = data_r[0];
          bit_n   = 3'd0;
        end else begin
          line_n = 1'b0;
        end
      end
      ST_DATA: begin
        if (baud_end_s && (bit_r == 3'd7)) begin
          bit_n = 3'd0;
          if (parity_on(par_r)) begin
            state_n = ST_PARITY;
            line_n  = parity_bit(data_r, par_r);
          end else begin
            state_n = ST_STOP;
            line_n  = 1'b1;
          end
        end else if (baud_end_s) begin
          bit_n  = bit_inc_s;
          line_n = data_r[bit_inc_s];
        end else begin
          line_n = data_r[bit_r];
        end
      end
      ST_PARITY: begin
        if (baud_end_s) begin
          state_n = ST_STOP;
          line_n  = 1'b1;
          bit_n   = 3'd0;
        end else begin
          line_n = parity_bit(data_r, par_r);
        end
      end
      ST_STOP: begin
        line_n = 1'b1;
        if (last_stop_s && (cnt_r == STOP_LAST)) begin
          state_n  = ST_IDLE;
          active_n = 1'b0;
          done_n   = 1'b1;
          cnt_n    = '0;
        end else if (baud_end_s) begin
          bit_n = bit_inc_s;
        end else begin
          bit_n = bit_r;
        end
      end
`ifdef UART_TX_SCHED_BREAK_EN
      ST_BREAK: begin
        line_n = 1'b0;
        if (baud_end_s && (brk_cnt_r == BRK_LAST)) begin
          state_n  = ST_IDLE;
          line_n   = 1'b1;
          active_n = 1'b0;
          done_n   = 1'b1;
        end else if (baud_end_s) begin
          brk_cnt_n = brk_cnt_r + BW'(1);
        end else begin
          brk_cnt_n = brk_cnt_r;
        end
      end
`endif
      default: begin
        state_n  = ST_IDLE;
        line_n   = 1'b1;
        active_n = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r  <= ST_IDLE;
      cnt_r    <= '0;
      bit_r    <= 3'd0;
      data_r   <= 8'd0;
      par_r    <= 2'd0;
      stop2_r  <= 1'b0;
      grant_r  <= 1'b0;
      ptr_r    <= 1'b1;
      line_r   <= 1'b1;
      active_r <= 1'b0;
      done_r   <= 1'b0;
`ifdef UART_TX_SCHED_BREAK_EN
      brk_cnt_r <= '0;
`endif
    end else begin
      state_r  <= state_n;
      cnt_r    <= cnt_n;
      bit_r    <= bit_n;
      data_r   <= data_n;
      par_r    <= par_n;
      stop2_r  <= stop2_n;
      grant_r  <= grant_n;
      ptr_r    <= ptr_n;
      line_r   <= line_n;
      active_r <= active_n;
      done_r   <= done_n;
`ifdef UART_TX_SCHED_BREAK_EN
      brk_cnt_r <= brk_cnt_n;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Scoreboard bench for uart_tx_scheduler: drivers push expected frames, a monitor decodes the line.
module tb_uart_tx_scheduler;
  localparam int CPB = 4;

  typedef struct packed {
    logic [7:0] data;
    logic [1:0] par;
    logic       stop2;
  } item_t;

  logic       clk;
  logic       rst;
  logic       req0_valid, req1_valid;
  logic [7:0] req0_data, req1_data;
  logic       req0_ready, req1_ready;
  logic [1:0] parity_type;
  logic       stop_bits;
`ifdef UART_TX_SCHED_BREAK_EN
  logic       break_req;
`endif
  logic       tx_line, tx_active, tx_done, grant_id;

  logic [7:0] stim0[$];
  logic [7:0] stim1[$];
  item_t      exp0[$];
  item_t      exp1[$];
  logic       grants[$];
  int         n_total = 0;
  int         n_pass  = 0;
  int         b2b_cnt = 0;
  logic       mon_busy = 1'b0;
  logic       ptr_m = 1'b1;

  uart_tx_scheduler #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .parity_type(parity_type), .stop_bits(stop_bits),
`ifdef UART_TX_SCHED_BREAK_EN
    .break_req(break_req),
`endif
    .tx_line(tx_line), .tx_active(tx_active), .tx_done(tx_done), .grant_id(grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Requester 0 driver: new byte after each acceptance, valid held while bytes remain
  initial begin : drv0
    logic acc;
    req0_valid = 1'b0;
    req0_data  = 8'h00;
    forever begin
      @(negedge clk);
      acc = req0_valid && req0_ready;
      @(posedge clk); #1;
      if (acc || !req0_valid) begin
        if (stim0.size() > 0) begin
          req0_data  = stim0.pop_front();
          req0_valid = 1'b1;
          exp0.push_back('{req0_data, parity_type, stop_bits});
        end else begin
          req0_valid = 1'b0;
        end
      end
    end
  end

  initial begin : drv1
    logic acc;
    req1_valid = 1'b0;
    req1_data  = 8'h00;
    forever begin
      @(negedge clk);
      acc = req1_valid && req1_ready;
      @(posedge clk); #1;
      if (acc || !req1_valid) begin
        if (stim1.size() > 0) begin
          req1_data  = stim1.pop_front();
          req1_valid = 1'b1;
          exp1.push_back('{req1_data, parity_type, stop_bits});
        end else begin
          req1_valid = 1'b0;
        end
      end
    end
  end

  // Monitor: predicts the winner, pops its expected frame and checks every line cycle
  initial begin : mon
    item_t      it;
    logic       win, pending, aborted, have;
    logic [11:0] bits;
    int         nb, ok, act_bad;
    forever begin
      @(negedge clk);
      if (!rst) ptr_m = 1'b1;
      pending = rst && (req0_ready || req1_ready);
      while (pending) begin
        pending = 1'b0;
        check("one_ready", {31'd0, req0_ready & req1_ready}, 32'd0);
        win = req1_valid && (!req0_valid || !ptr_m);
        check("grant_sel", {31'd0, req1_ready}, {31'd0, win});
        ptr_m = win;
        grants.push_back(win);
        have = win ? (exp1.size() > 0) : (exp0.size() > 0);
        check("exp_avail", {31'd0, have}, 32'd1);
        if (have) begin
          it = win ? exp1.pop_front() : exp0.pop_front();
          bits = 12'hFFF;
          bits[0] = 1'b0;
          bits[8:1] = it.data;
          nb = 10 + int'(it.stop2);
          if (it.par == 2'b01 || it.par == 2'b10) begin
            bits[9] = (it.par == 2'b01) ? ~^it.data : ^it.data;
            nb = nb + 1;
          end
          mon_busy = 1'b1;
          aborted = 1'b0;
          act_bad = 0;
          for (int b = 0; b < nb && !aborted; b++) begin
            ok = 0;
            for (int c = 0; c < CPB && !aborted; c++) begin
              @(negedge clk);
              if (!rst) begin
                aborted = 1'b1;
                ptr_m = 1'b1;
              end else begin
                if (tx_line == bits[b]) ok++;
                if (!((b == nb - 1) && (c == CPB - 1)) &&
                    (!tx_active || tx_done || req0_ready || req1_ready)) act_bad++;
                if (b == 0 && c == 0) check("grant_id", {31'd0, grant_id}, {31'd0, win});
              end
            end
            if (!aborted) check($sformatf("bit%0d", b), ok, CPB);
          end
          if (!aborted) begin
            check("frame_ctrl", act_bad, 32'd0);
            check("done_pulse", {31'd0, tx_done}, 32'd1);
            check("active_end", {31'd0, tx_active}, 32'd0);
            if (req0_ready || req1_ready) begin
              pending = 1'b1;
              b2b_cnt++;
            end
          end
          mon_busy = 1'b0;
        end
      end
    end
  end

  task automatic wait_drain(input int budget);
    int n = 0;
    while (n < budget && !(stim0.size() == 0 && stim1.size() == 0 && exp0.size() == 0 &&
                           exp1.size() == 0 && !mon_busy)) begin
      @(negedge clk);
      n++;
    end
    check("drain", {31'd0, n < budget}, 32'd1);
  endtask

  task automatic wait_busy(input int budget);
    int n = 0;
    while (n < budget && !mon_busy) begin
      @(negedge clk);
      n++;
    end
    check("start", {31'd0, mon_busy}, 32'd1);
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk); #1 rst = 1'b1;
  endtask

  initial begin : main
    rst = 1'b0;
    parity_type = 2'b00;
    stop_bits = 1'b0;
`ifdef UART_TX_SCHED_BREAK_EN
    break_req = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("reset_state", {26'd0, tx_line, tx_active, tx_done, req0_ready, req1_ready, grant_id},
          32'h20);
    @(posedge clk); #1 rst = 1'b1;

    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check("idle", {27'd0, tx_line, tx_active, tx_done, req0_ready, req1_ready}, 32'h10);
    end

    parity_type = 2'b10;
    stop_bits = 1'b0;
    stim0.push_back(8'hA5);
    wait_drain(200);

    do_reset();
    parity_type = 2'b00;
    grants.delete();
    b2b_cnt = 0;
    stim0.push_back(8'h11); stim0.push_back(8'h11);
    stim1.push_back(8'h22); stim1.push_back(8'h22);
    wait_drain(600);
    check("rr_count", grants.size(), 32'd4);
    for (int i = 0; i < grants.size(); i++) check("rr_order", {31'd0, grants[i]}, i % 2);
    check("b2b", b2b_cnt, 32'd3);

    parity_type = 2'b01;
    stop_bits = 1'b1;
    stim0.push_back(8'hFF);
    wait_drain(200);

    parity_type = 2'b00;
    stop_bits = 1'b0;
    stim0.push_back(8'h3C);
    wait_busy(50);
    repeat (14) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("rst_line", {31'd0, tx_line}, 32'd1);
    check("rst_active", {31'd0, tx_active}, 32'd0);
    repeat (2) @(negedge clk);
    @(posedge clk); #1 rst = 1'b1;
    stim1.push_back(8'h5A);
    wait_drain(200);

`ifdef UART_TX_SCHED_BREAK_EN
    begin
      int n, n_low;
      stim0.push_back(8'h44);
      wait_busy(50);
      repeat (5) @(negedge clk);
      break_req = 1'b1;
      stim1.push_back(8'h77);
      n = 0;
      while (n < 200 && !tx_done) begin
        @(negedge clk);
        n++;
      end
      check("brk_frame_end", {31'd0, tx_done}, 32'd1);
      check("brk_prio", {31'd0, req1_ready}, 32'd0);
      @(posedge clk); #1 break_req = 1'b0;
      n = 0;
      n_low = 0;
      @(negedge clk);
      while (n < 200 && !tx_done) begin
        if (tx_line == 1'b0 && tx_active) n_low++;
        @(negedge clk);
        n++;
      end
      check("brk_len", n_low, 32'd48);
      check("brk_done", {31'd0, tx_done}, 32'd1);
      wait_drain(200);
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
